// File: rtl/input_ctrl_sync.sv
// input_ctrl_sync: one router input port. It buffers packets, computes an XY route for the head, and requests one output slot.
// Define INCTRL_DROP_CNT_EN to add the saturating drop_cnt output, which counts dropped U-turn packets.
module input_ctrl_sync #(
  parameter int unsigned WIDTH_packet = 57,
  parameter int unsigned X_ID         = 0,
  parameter int unsigned Y_ID         = 0,
  parameter int unsigned PORT_DIR     = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH_packet-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH_packet-1:0] out_data,
  output logic [3:0]              out_valid,
  input  logic [3:0]              out_ready,
  output logic                    route_err
`ifdef INCTRL_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] DIR_N = 3'd0;
  localparam logic [2:0] DIR_E = 3'd1;
  localparam logic [2:0] DIR_S = 3'd2;
  localparam logic [2:0] DIR_W = 3'd3;
  localparam logic [2:0] DIR_L = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ROUTE = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [WIDTH_packet-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    in_ready_q, in_ready_d;
  logic [WIDTH_packet-1:0] out_data_q, out_data_d;
  logic [3:0]              out_valid_q, out_valid_d;
  logic                    route_err_q, route_err_d;

  logic                    push;
  logic                    pop;
  logic [WIDTH_packet-1:0] head;
  logic [2:0]              head_dir;
  logic                    head_uturn;
  logic                    remain_after_pop;

  // XY dimension-order routing: resolve x first, then y, else deliver locally.
  function automatic logic [2:0] xy_route(input logic [1:0] dx, input logic [1:0] dy);
    logic [2:0] dir;
    dir = DIR_L;
    if (dx > 2'(X_ID)) begin
      dir = DIR_E;
    end else if (dx < 2'(X_ID)) begin
      dir = DIR_W;
    end else if (dy > 2'(Y_ID)) begin
      dir = DIR_N;
    end else if (dy < 2'(Y_ID)) begin
      dir = DIR_S;
    end
    return dir;
  endfunction

  // Slots list the four non-own directions in ascending order, so directions above PORT_DIR shift down by one.
  function automatic logic [3:0] dir_to_slot(input logic [2:0] dir);
    logic [2:0] idx;
    idx = (dir > 3'(PORT_DIR)) ? (dir - 3'd1) : dir;
    return 4'b0001 << idx;
  endfunction

  assign push             = in_valid & in_ready_q;
  assign head             = mem_q[rd_ptr_q];
  assign head_dir         = xy_route(head[WIDTH_packet-1 -: 2], head[WIDTH_packet-3 -: 2]);
  assign head_uturn       = (head_dir == 3'(PORT_DIR));
  assign remain_after_pop = (count_q > CNT_W'(1)) | push;

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    route_err_d = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ROUTE;
        end
      end
      ST_ROUTE: begin
        out_data_d = head;
        if (head_uturn) begin
          pop         = 1'b1;
          route_err_d = 1'b1;
          state_d     = remain_after_pop ? ST_ROUTE : ST_EMPTY;
        end else begin
          out_valid_d = dir_to_slot(head_dir);
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if ((out_valid_q & out_ready) != 4'b0000) begin
          pop         = 1'b1;
          out_valid_d = 4'b0000;
          state_d     = remain_after_pop ? ST_ROUTE : ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // FIFO bookkeeping. Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    in_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      route_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      route_err_q <= route_err_d;
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign route_err = route_err_q;

`ifdef INCTRL_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped U-turn packets. It updates on the same edge that raises route_err.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (route_err_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  a_valid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(out_valid_q));
  a_count_bound:  assert property (@(posedge clk) disable iff (reset) count_q <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_input_ctrl_sync.sv
// Self-checking bench for input_ctrl_sync: a scoreboard of expected slot/data/drop per accepted packet.
// It runs directed latency, hold, U-turn, fill/drain and reset scenarios, then a random phase.
module tb_input_ctrl_sync;

  localparam int W          = 57;
  localparam int X_ID       = 1;
  localparam int Y_ID       = 1;
  localparam int PORT_DIR   = 1;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   slot;
    logic         drop;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic         route_err;
`ifdef INCTRL_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  input_ctrl_sync #(
    .WIDTH_packet(W),
    .X_ID(X_ID),
    .Y_ID(Y_ID),
    .PORT_DIR(PORT_DIR),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .route_err(route_err)
`ifdef INCTRL_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   occ = 0;
  int   drops_exp = 0;
  bit   held = 1'b0;
  logic [3:0]   held_valid = '0;
  logic [W-1:0] held_data = '0;
  logic rst_last = 1'b0;
  bit   seen = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: XY routing, U-turn detection and slot numbering taken directly from the routing rules.
  function automatic exp_t model(input logic [W-1:0] p);
    exp_t e;
    int dx, dy, dir, idx;
    dx = int'(p[56:55]);
    dy = int'(p[54:53]);
    if (dx > X_ID)      dir = 1;
    else if (dx < X_ID) dir = 3;
    else if (dy > Y_ID) dir = 0;
    else if (dy < Y_ID) dir = 2;
    else                dir = 4;
    idx = 0;
    for (int d = 0; d < dir; d++) if (d != PORT_DIR) idx++;
    e.data = p;
    e.drop = (dir == PORT_DIR);
    e.slot = e.drop ? 4'b0000 : 4'(1 << idx);
    return e;
  endfunction

  function automatic logic [W-1:0] mk(input int dx, input int dy, input int src, input logic [48:0] pl);
    return {2'(dx), 2'(dy), 4'(src), pl};
  endfunction

  always @(posedge clk) begin
    rst_last <= reset;
    if (reset) seen <= 1'b1;
  end

  // Monitor: checks outputs against the scoreboard and predicts the handshakes at the next edge.
  always @(negedge clk) begin
    if (seen) begin
      if (rst_last) begin
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_route_err", 64'(route_err), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        exp_q.delete();
        occ = 0;
        drops_exp = 0;
        held = 1'b0;
      end else begin
        if (route_err) begin
          if (exp_q.size() == 0) chk("err_unexpected", 64'(1), 64'(0));
          else begin
            chk("err_is_drop", 64'(exp_q[0].drop), 64'(1));
            void'(exp_q.pop_front());
            occ--;
          end
          drops_exp = (drops_exp >= 255) ? 255 : drops_exp + 1;
        end
        chk("in_ready", 64'(in_ready), 64'(occ != FIFO_DEPTH));
        if (held) begin
          chk("hold_valid", 64'(out_valid), 64'(held_valid));
          chk("hold_data", 64'(out_data), 64'(held_data));
        end
        if (out_valid != 4'b0000) begin
          if (exp_q.size() == 0) chk("valid_unexpected", 64'(out_valid), 64'(0));
          else begin
            chk("slot", 64'(out_valid), 64'(exp_q[0].slot));
            chk("data", 64'(out_data), 64'(exp_q[0].data));
          end
        end
      end
`ifdef INCTRL_DROP_CNT_EN
      chk("drop_cnt", 64'(drop_cnt), 64'(drops_exp));
`endif
      held = 1'b0;
      if (!reset) begin
        if (out_valid != 4'b0000 && (out_valid & out_ready) != 4'b0000) begin
          if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            occ--;
          end
        end else if (out_valid != 4'b0000) begin
          held = 1'b1;
          held_valid = out_valid;
          held_data = out_data;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(in_data));
          occ++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    cyc();
    while ((exp_q.size() != 0 || out_valid != 4'b0000) && n < budget) begin
      cyc();
      n++;
    end
    chk("idle_reached", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic push1(input logic [W-1:0] p);
    in_data = p;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid == 4'b0000 && !route_err && lat < 20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc, k, last;
    bit chk_next;
    logic [W-1:0] p;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cyc();

    // Route north to slot0, with a two-edge latency and a pop on the slot's ready.
    wait_idle(50);
    p = mk(1, 2, 3, 49'h1234);
    push1(p);
    wait_out(lat);
    chk("t1_latency", 64'(lat), 64'(2));
    chk("t1_slot", 64'(out_valid), 64'(4'b0001));
    chk("t1_payload", 64'(out_data[48:0]), 64'(49'h1234));
    repeat (2) cyc();
    out_ready = 4'b0001;
    cyc();
    out_ready = 4'b0000;
    @(negedge clk);
    chk("t1_popped", 64'(out_valid), 64'(0));

    // Local delivery goes to slot3; ready on other slots must not pop it.
    wait_idle(50);
    p = mk(1, 1, 2, 49'h55);
    push1(p);
    wait_out(lat);
    chk("t2_slot", 64'(out_valid), 64'(4'b1000));
    cyc();
    out_ready = 4'b0111;
    repeat (10) cyc();
    @(negedge clk);
    chk("t2_hold_valid", 64'(out_valid), 64'(4'b1000));
    chk("t2_hold_data", 64'(out_data), 64'(p));
    cyc();
    out_ready = 4'b1000;
    cyc();
    out_ready = 4'b0000;
    @(negedge clk);
    chk("t2_popped", 64'(out_valid), 64'(0));

    // A U-turn to the east is dropped with a single route_err pulse.
    wait_idle(50);
    push1(mk(2, 0, 1, 49'h77));
    wait_out(lat);
    chk("t3_err_latency", 64'(lat), 64'(2));
    chk("t3_err", 64'(route_err), 64'(1));
    chk("t3_no_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("t3_err_pulse", 64'(route_err), 64'(0));
    cyc();
    for (int i = 0; i < 300; i++) begin
      in_data = mk(2 + int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1, 49'(i));
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    wait_idle(50);
`ifdef INCTRL_DROP_CNT_EN
    @(negedge clk);
    chk("t3_drop_sat", 64'(drop_cnt), 64'(255));
`endif

    // Fill the FIFO with six pushes; only four fit. Then drain in order at one packet per two cycles.
    out_ready = 4'b0000;
    wait_idle(50);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_data = mk(1, 0, 0, 49'(i));
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      cyc();
    end
    in_valid = 1'b0;
    chk("t4_accepted", 64'(acc), 64'(4));
    @(negedge clk);
    chk("t4_full_ready", 64'(in_ready), 64'(0));
    cyc();
    out_ready = 4'b0010;
    k = 0;
    last = 0;
    chk_next = 1'b0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      if (chk_next) begin
        chk("t4_ready_after_pop", 64'(in_ready), 64'(1));
        chk_next = 1'b0;
      end
      if (out_valid[1] && out_ready[1]) begin
        chk("t4_order", 64'(out_data[7:0]), 64'(k));
        if (k == 0) chk_next = 1'b1;
        else chk("t4_gap", 64'(c - last), 64'(2));
        last = c;
        k++;
      end
    end
    chk("t4_drained", 64'(k), 64'(4));
    cyc();
    out_ready = 4'b0000;

    // Reset with three packets buffered discards all of them.
    wait_idle(50);
    for (int i = 0; i < 3; i++) begin
      in_data = mk(0, 1, 0, 49'(8'hA0 + i));
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    wait_out(lat);
    chk("t5_valid_before", 64'(out_valid), 64'(4'b0100));
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", 64'(out_valid), 64'(0));
    chk("t5_rst_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("t5_ready_back", 64'(in_ready), 64'(1));
    cyc();
    p = mk(1, 2, 5, 49'hBEEF);
    out_ready = 4'b1111;
    push1(p);
    wait_out(lat);
    chk("t5_first_after_rst", 64'(out_data), 64'(p));
    wait_idle(50);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_data = W'({$urandom, $urandom});
      out_ready = 4'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 4'b1111;
    wait_idle(300);
    @(negedge clk);
    chk("final_valid", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
